// File: rtl/divide_controller_pkg.sv
// Shared types and constants for the EX-stage divide sequencer.
// Operand width is fixed here because the request/result structs depend on it.
package divide_controller_params;

  localparam int DIV_DATA_WIDTH      = 32;
  localparam int DEFAULT_MAX_LATENCY = 64;

  typedef logic [DIV_DATA_WIDTH-1:0] div_word_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD,
    DRAIN
  } DivideState;

  typedef struct packed {
    logic      is_signed;
    div_word_t dividend;
    div_word_t divisor;
  } DivideRequest;

  typedef struct packed {
    div_word_t quotient;
    div_word_t remainder;
  } DivideResult;

endpackage

// File: rtl/divide_controller.sv
// Sequences one divide at a time through the stream-handshake divider IP,
// holds the result for the IO stage and stalls EX until it is available.
module divide_controller
  import divide_controller_params::*;
#(
  parameter int DATA_WIDTH  = DIV_DATA_WIDTH,
  parameter int MAX_LATENCY = DEFAULT_MAX_LATENCY,
  parameter int COUNT_WIDTH = 7
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  request_valid,
  input  logic                  request_signed,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  flush,
  input  logic                  result_accept,
  output logic                  ready_go,
  output logic                  result_valid,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_in_valid,
  output logic                  div_in_signed,
  input  logic                  div_in_ready,
  output logic [DATA_WIDTH-1:0] div_dividend,
  output logic [DATA_WIDTH-1:0] div_divisor,
  input  logic                  div_out_valid,
  input  logic [DATA_WIDTH-1:0] div_out_quotient,
  input  logic [DATA_WIDTH-1:0] div_out_remainder,
  output logic                  timeout_error
);

  if (DATA_WIDTH != DIV_DATA_WIDTH) begin : g_bad_data_width
    $error("DATA_WIDTH must equal divide_controller_params::DIV_DATA_WIDTH");
  end
  if ((2 ** COUNT_WIDTH) <= MAX_LATENCY) begin : g_bad_count_width
    $error("COUNT_WIDTH too small for MAX_LATENCY");
  end

  localparam logic [COUNT_WIDTH-1:0] WD_LIMIT = COUNT_WIDTH'(MAX_LATENCY);
  localparam logic [COUNT_WIDTH-1:0] WD_LAST  = COUNT_WIDTH'(MAX_LATENCY - 1);

  DivideState             state_q;
  DivideRequest           req_q;
  DivideResult            res_q;
  logic                   cancel_q;
  logic                   div_in_valid_q;
  logic                   result_valid_q;
  logic                   ready_go_q;
  logic                   timeout_q;
  logic [COUNT_WIDTH-1:0] wd_q;
  logic [COUNT_WIDTH-1:0] wd_d;

  // Watchdog saturates so a very late response cannot wrap it back to zero.
  always_comb begin
    wd_d = wd_q;
    if (wd_q != WD_LIMIT) wd_d = wd_q + COUNT_WIDTH'(1);
  end

  // NOTE: every register, including the datapath latches, is cleared by the
  // asynchronous reset so all outputs read 0 the moment reset_n falls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      req_q          <= '0;
      res_q          <= '0;
      cancel_q       <= 1'b0;
      div_in_valid_q <= 1'b0;
      result_valid_q <= 1'b0;
      ready_go_q     <= 1'b0;
      timeout_q      <= 1'b0;
      wd_q           <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // branch below sees the pre-edge value of state_q and friends.
      case (state_q)
        IDLE: begin
          if (request_valid && !flush) begin
            req_q.is_signed <= request_signed;
            req_q.dividend  <= dividend;
            req_q.divisor   <= divisor;
            cancel_q        <= 1'b0;
            div_in_valid_q  <= 1'b1;
            state_q         <= ISSUE;
          end
        end
        ISSUE: begin
          // The operand beat cannot be withdrawn, so a flush here only marks
          // the eventual result for discard.
          if (div_in_ready) begin
            div_in_valid_q <= 1'b0;
            cancel_q       <= 1'b0;
            wd_q           <= '0;
            state_q        <= (cancel_q || flush) ? DRAIN : WAIT;
          end else if (flush) begin
            cancel_q <= 1'b1;
          end
        end
        WAIT: begin
          wd_q <= wd_d;
          if (wd_q == WD_LAST) timeout_q <= 1'b1;
          if (flush) begin
            wd_q    <= '0;
            state_q <= div_out_valid ? IDLE : DRAIN;
          end else if (div_out_valid) begin
            res_q.quotient  <= div_out_quotient;
            res_q.remainder <= div_out_remainder;
            result_valid_q  <= 1'b1;
            ready_go_q      <= 1'b1;
            state_q         <= HOLD;
          end
        end
        HOLD: begin
          if (flush || result_accept) begin
            result_valid_q <= 1'b0;
            ready_go_q     <= 1'b0;
            state_q        <= IDLE;
          end
        end
        DRAIN: begin
          wd_q <= wd_d;
          if (wd_q == WD_LAST) timeout_q <= 1'b1;
          if (div_out_valid) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_go      = ready_go_q;
  assign result_valid  = result_valid_q;
  assign quotient      = res_q.quotient;
  assign remainder     = res_q.remainder;
  assign div_in_valid  = div_in_valid_q;
  assign div_in_signed = req_q.is_signed;
  assign div_dividend  = req_q.dividend;
  assign div_divisor   = req_q.divisor;
  assign timeout_error = timeout_q;

endmodule

// File: tb/tb_divide_controller.sv
// Directed bench for divide_controller: behavioural divider with programmable
// latency, expected results queued by stimulus and checked by a monitor.
module tb_divide_controller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        request_valid = 1'b0;
  logic        request_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        flush = 1'b0;
  logic        result_accept = 1'b0;
  logic        ready_go;
  logic        result_valid;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_in_valid;
  logic        div_in_signed;
  logic        div_in_ready = 1'b1;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_out_valid = 1'b0;
  logic [31:0] div_out_quotient = '0;
  logic [31:0] div_out_remainder = '0;
  logic        timeout_error;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  int          m_lat = 10;
  int          m_cnt = 0;
  bit          m_respond = 1'b1;
  logic [31:0] m_q, m_r;

  divide_controller dut (
    .clock(clock), .reset_n(reset_n),
    .request_valid(request_valid), .request_signed(request_signed),
    .dividend(dividend), .divisor(divisor),
    .flush(flush), .result_accept(result_accept),
    .ready_go(ready_go), .result_valid(result_valid),
    .quotient(quotient), .remainder(remainder),
    .div_in_valid(div_in_valid), .div_in_signed(div_in_signed),
    .div_in_ready(div_in_ready),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_out_valid(div_out_valid),
    .div_out_quotient(div_out_quotient), .div_out_remainder(div_out_remainder),
    .timeout_error(timeout_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic sg, input logic [31:0] a, input logic [31:0] b);
    request_valid  = 1'b1;
    request_signed = sg;
    dividend       = a;
    divisor        = b;
    tick(1);
    request_valid  = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int k = 0;
    while (!result_valid && k < 200) begin
      tick(1);
      k++;
    end
    check({name, "_result_seen"}, 64'(result_valid), 64'd1);
  endtask

  task automatic accept_result();
    result_accept = 1'b1;
    tick(1);
    result_accept = 1'b0;
  endtask

  // Behavioural divider: the beat accepted at edge N answers m_lat edges later.
  initial begin
    bit hs;
    forever begin
      @(negedge clock);
      hs = div_in_valid && div_in_ready && reset_n;
      if (hs) begin
        if (div_in_signed) begin
          m_q = $signed(div_dividend) / $signed(div_divisor);
          m_r = $signed(div_dividend) % $signed(div_divisor);
        end else begin
          m_q = div_dividend / div_divisor;
          m_r = div_dividend % div_divisor;
        end
      end
      @(posedge clock);
      #1;
      div_out_valid = 1'b0;
      if (!reset_n) m_cnt = 0;
      else if (hs) m_cnt = m_lat;
      else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0 && m_respond) begin
          div_out_valid     = 1'b1;
          div_out_quotient  = m_q;
          div_out_remainder = m_r;
        end
      end
    end
  end

  // Monitor: every new result presentation must match the oldest expectation.
  initial begin
    bit rv_prev = 1'b0;
    logic [63:0] e;
    forever begin
      @(negedge clock);
      if (result_valid && !rv_prev) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_result", {quotient, remainder}, 64'hDEAD_BEEF_DEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          check("sb_quotient", 64'(quotient), 64'(e[63:32]));
          check("sb_remainder", 64'(remainder), 64'(e[31:0]));
        end
      end
      rv_prev = result_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int  k;
    bit  flag;

    // Reset state
    #1;
    check("rst_ready_go", 64'(ready_go), 64'd0);
    check("rst_result_valid", 64'(result_valid), 64'd0);
    check("rst_div_in_valid", 64'(div_in_valid), 64'd0);
    check("rst_quot_rem", {quotient, remainder}, 64'd0);
    check("rst_timeout", 64'(timeout_error), 64'd0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // Unsigned 7/2, latency 10: result on cycle 13, ready_go only then
    m_lat = 10;
    div_in_ready = 1'b1;
    request_valid = 1'b1; request_signed = 1'b0; dividend = 32'd7; divisor = 32'd2;
    exp_q.push_back({32'd3, 32'd1});
    k = 0; flag = 1'b0;
    while (k < 40) begin
      tick(1);
      k++;
      if (result_valid) break;
      if (ready_go) flag = 1'b1;
    end
    check("t1_latency", 64'(k), 64'd13);
    check("t1_ready_go_early", 64'(flag), 64'd0);
    check("t1_ready_go_hold", 64'(ready_go), 64'd1);
    result_accept = 1'b1;
    tick(1);
    request_valid = 1'b0; result_accept = 1'b0;
    check("t1_hold_exit", 64'(result_valid), 64'd0);
    tick(2);
    check("t1_no_reissue", 64'(div_in_valid), 64'd0);

    // Signed -7/2 with a short ready stall; signed select held in ISSUE
    m_lat = 4;
    div_in_ready = 1'b0;
    send(1'b1, 32'hFFFF_FFF9, 32'd2);
    exp_q.push_back({32'hFFFF_FFFD, 32'hFFFF_FFFF});
    flag = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (!(div_in_valid && div_in_signed)) flag = 1'b0;
      if (i == 2) div_in_ready = 1'b1;
      tick(1);
    end
    check("t2_signed_in_issue", 64'(flag), 64'd1);
    wait_result("t2");
    accept_result();

    // div_in_ready low for 5 cycles: valid and operands hold
    m_lat = 6;
    div_in_ready = 1'b0;
    send(1'b0, 32'h1234_5678, 32'h10);
    exp_q.push_back({32'h0123_4567, 32'h8});
    flag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!div_in_valid || div_dividend !== 32'h1234_5678 || div_divisor !== 32'h10 ||
          div_in_signed !== 1'b0) flag = 1'b0;
      tick(1);
    end
    check("t3_operands_stable", 64'(flag), 64'd1);
    check("t3_valid_before_ready", 64'(div_in_valid), 64'd1);
    div_in_ready = 1'b1;
    tick(1);
    check("t3_wait_after_ready", 64'(div_in_valid), 64'd0);
    wait_result("t3");
    accept_result();

    // Flush 3 cycles into WAIT; next request must wait for the DRAIN exit
    m_lat = 10;
    send(1'b0, 32'd80, 32'd3);
    tick(4);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    request_valid = 1'b1; request_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    exp_q.push_back({32'd14, 32'd2});
    k = 6; flag = 1'b0;
    while (!div_in_valid && k < 60) begin
      if (ready_go || result_valid) flag = 1'b1;
      tick(1);
      k++;
    end
    check("t4_reissue_cycle", 64'(k), 64'd14);
    check("t4_drain_no_output", 64'(flag), 64'd0);
    check("t4_new_dividend", 64'(div_dividend), 64'd100);
    wait_result("t4");
    result_accept = 1'b1;
    tick(1);
    request_valid = 1'b0; result_accept = 1'b0;

    // HOLD stable for 4 cycles, then flush together with accept
    m_lat = 3;
    send(1'b0, 32'd1000, 32'd33);
    exp_q.push_back({32'd30, 32'd10});
    wait_result("t5");
    flag = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!result_valid || !ready_go || quotient !== 32'd30 || remainder !== 32'd10) flag = 1'b0;
      tick(1);
    end
    check("t5_hold_stable", 64'(flag), 64'd1);
    flush = 1'b1; result_accept = 1'b1;
    tick(1);
    flush = 1'b0; result_accept = 1'b0;
    check("t5_flush_accept_rv", 64'(result_valid), 64'd0);
    check("t5_flush_accept_go", 64'(ready_go), 64'd0);

    // Divider never answers: watchdog after 64 WAIT cycles, then async reset
    m_respond = 1'b0;
    send(1'b0, 32'd5, 32'd1);
    tick(64);
    check("t6_timeout_not_yet", 64'(timeout_error), 64'd0);
    tick(1);
    check("t6_timeout_set", 64'(timeout_error), 64'd1);
    tick(3);
    check("t6_timeout_sticky", 64'(timeout_error), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_timeout", 64'(timeout_error), 64'd0);
    check("t6_rst_quot_rem", {quotient, remainder}, 64'd0);
    check("t6_rst_operands", {div_dividend, div_divisor}, 64'd0);
    check("t6_rst_handshake", {61'd0, div_in_valid, result_valid, ready_go}, 64'd0);
    m_cnt = 0;
    m_respond = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(1);

    // Recovery after reset: signed -100 / -7
    m_lat = 5;
    send(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    exp_q.push_back({32'd14, 32'hFFFF_FFFE});
    wait_result("t7");
    accept_result();
    tick(3);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/divide_controller.md
Name: divide_controller

Overview:
- Multi-cycle sequencer between the EX stage and the pipelined divider IP (AXI-stream style operand/result channels).
- Accepts one divide request at a time, drives the divider handshake and holds quotient/remainder until the IO stage accepts them.
- Supplies the stall term for EX ready_go.
- Discards in-flight results cancelled by a WB exception or eret flush.

Parameters:
DATA_WIDTH, 32, operand/result width
MAX_LATENCY, 64, cycles allowed in WAIT/DRAIN before timeout_error sets
COUNT_WIDTH, 7, watchdog counter width; must satisfy 2**COUNT_WIDTH > MAX_LATENCY

Ports:
clock  in  1  single clock; all state on rising edge
reset_n  in  1  asynchronous active-low reset
request_valid  in  1  EX holds a valid divide instruction (ex_valid & divide_valid)
request_signed  in  1  1 = DIV, 0 = DIVU
dividend  in  DATA_WIDTH  rs value
divisor  in  DATA_WIDTH  rt value
flush  in  1  WB exception_valid | eret_flush
result_accept  in  1  downstream allow_in
ready_go  out  1  EX may advance the divide instruction
result_valid  out  1  quotient/remainder valid
quotient  out  DATA_WIDTH  registered quotient
remainder  out  DATA_WIDTH  registered remainder
div_in_valid  out  1  operand channel valid
div_in_signed  out  1  selects the signed divider instance
div_in_ready  in  1  operand channel ready
div_dividend  out  DATA_WIDTH  latched dividend
div_divisor  out  DATA_WIDTH  latched divisor
div_out_valid  in  1  divider result valid, one-cycle pulse
div_out_quotient  in  DATA_WIDTH  divider quotient
div_out_remainder  in  DATA_WIDTH  divider remainder
timeout_error  out  1  sticky watchdog flag

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE.
  - All outputs 0, including quotient/remainder, timeout_error and the watchdog counter.
  - Reset mid-operation abandons any transaction; the divider IP is reset by the same signal.
- States: IDLE, ISSUE, WAIT, HOLD, DRAIN.
- IDLE:
  - request_valid & !flush → latch dividend, divisor and request_signed; go to ISSUE next cycle.
  - ready_go=0 while request_valid.
- ISSUE:
  - div_in_valid=1 with stable operands and signed select.
  - div_in_valid never drops before div_in_ready (stream rule).
  - On div_in_ready → WAIT; or → DRAIN if a cancel was recorded.
  - flush in ISSUE sets the cancel flag; the handshake still completes.
- WAIT:
  - On div_out_valid → latch quotient/remainder, go to HOLD.
  - flush → DRAIN.
  - flush coincident with div_out_valid → IDLE; result discarded.
- HOLD:
  - result_valid=1 and ready_go=1.
  - result_accept → IDLE.
  - flush → IDLE.
  - flush and result_accept in the same cycle → flush wins, IDLE; the IO stage also invalidates.
- DRAIN:
  - ready_go=0; new requests are not accepted.
  - On div_out_valid → discard, go to IDLE.
- Minimum latency: request in IDLE to ready_go = 2 + handshake wait + divider latency + 1 cycles.
- Watchdog counter:
  - Clears on entering WAIT/DRAIN and increments each cycle in those states.
  - Reaching MAX_LATENCY sets timeout_error, which stays set until reset.
  - The state machine keeps waiting regardless.
- Division by zero: passed through unmodified; no exception (architecturally undefined).
- Spurious div_out_valid in IDLE/ISSUE/HOLD is ignored.
- A request in the cycle HOLD exits is not taken until the next cycle in IDLE; no back-to-back bypass.
- Results are only presented in HOLD; no combinational path from div_out_* to quotient/remainder.

Decomposition:
- Package divide_controller_params holds:
  - DivideState enum (IDLE, ISSUE, WAIT, HOLD, DRAIN)
  - DivideRequest struct (signed, dividend, divisor)
  - DivideResult struct (quotient, remainder)
  - default MAX_LATENCY constant
- No sub-module needed; the watchdog stays inline.
- The bench supplies a behavioural divider model with configurable latency and ready stalls.

Test Plan:
- Unsigned 7/2, divider latency 10, div_in_ready=1 → quotient=3, remainder=1; result_valid on cycle 13 after request; ready_go only then.
- Signed 0xFFFFFFF9/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; div_in_signed=1 for the whole ISSUE state.
- div_in_ready held low 5 cycles → div_in_valid stays 1 with constant operands; WAIT entered the cycle after ready rises.
- flush 3 cycles into WAIT, then a new request 100/7 → first result discarded in DRAIN; second result quotient=14, remainder=2; the new request is not accepted before the DRAIN exit.
- HOLD with result_accept=0 for 4 cycles → outputs stable; flush together with result_accept → IDLE, result_valid=0 next cycle.
- Divider never responds → timeout_error=1 after MAX_LATENCY (64) cycles in WAIT; reset_n pulsed low mid-WAIT → IDLE and all outputs 0 immediately, without waiting for a clock edge.
